// File: rtl/ysyx_23060180_mem_pkg.sv
// rtl/ysyx_23060180_mem_pkg.sv - shared types and defaults for the IFU/LSU memory arbiter
package ysyx_23060180_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/ysyx_23060180_mem_arbiter_rr_arb2.sv
// rtl/ysyx_23060180_mem_arbiter_rr_arb2.sv - two-way round-robin arbiter, bit 0 = IFU, bit 1 = LSU
module ysyx_23060180_rr_arb2
    import ysyx_23060180_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rstn_in,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    req_id_t last_q;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == REQ_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            last_q <= REQ_LSU;
        end else if (accept && (grant != 2'b00)) begin
            last_q <= grant[1] ? REQ_LSU : REQ_IFU;
        end
    end

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// rtl/ysyx_23060180_mem_arbiter.sv - shares one fixed-latency memory port between IFU and LSU
module ysyx_23060180_mem_arbiter
    import ysyx_23060180_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn_in,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
            $error("ysyx_23060180_mem_arbiter: MEM_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t     state_q, state_d;
    req_id_t    owner_q;
    logic       is_store_q;
    logic [2:0] cnt_q;
    logic [1:0] grant;
    logic       accept;
    logic       sel_lsu;
    logic       sel_store;
    logic       last_wait;

    ysyx_23060180_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rstn_in (rstn_in),
        .req     ({lsu_req_valid, ifu_req_valid}),
        .accept  (accept),
        .grant   (grant)
    );

    // Ready is only offered in IDLE, so a request raised during RESP waits a cycle.
    assign ifu_req_ready = (state_q == IDLE) && grant[0];
    assign lsu_req_ready = (state_q == IDLE) && grant[1];
    assign accept        = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);
    assign sel_lsu       = grant[1];
    assign sel_store     = sel_lsu && lsu_req_wen;
    assign last_wait     = (state_q == WAIT) && (cnt_q == 3'd1);

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 3'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are set on the accepting edge so they are high exactly during ISSUE.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            owner_q        <= REQ_LSU;
            is_store_q     <= 1'b0;
            cnt_q          <= 3'd0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
        end else begin
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (accept) begin
                owner_q    <= sel_lsu ? REQ_LSU : REQ_IFU;
                is_store_q <= sel_store;
                mem_rd     <= !sel_store;
                mem_wr     <= sel_store;
                mem_addr   <= sel_lsu ? lsu_req_addr : ifu_req_addr;
                mem_wdata  <= sel_store ? lsu_req_wdata : '0;
                mem_wmask  <= sel_store ? lsu_req_wmask : '0;
            end

            if (state_q == ISSUE) begin
                cnt_q <= LAT_INIT;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end

            if (last_wait) begin
                if (owner_q == REQ_IFU) begin
                    ifu_resp_valid <= 1'b1;
                    ifu_resp_data  <= mem_rdata;
                end else begin
                    lsu_resp_valid <= 1'b1;
                    lsu_resp_data  <= is_store_q ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// tb/tb_ysyx_23060180_mem_arbiter.sv - directed bench for the IFU/LSU memory arbiter at MEM_LAT 1 and 3
module tb_ysyx_23060180_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn_in = 1'b0;
    int          total = 0;
    int          bad = 0;

    // instance with MEM_LAT=1
    logic        i1_v = 0, i1_rdy, i1_rv;
    logic [31:0] i1_addr = 0, i1_rd;
    logic        l1_v = 0, l1_rdy, l1_wen = 0, l1_rv;
    logic [31:0] l1_addr = 0, l1_wdata = 0, l1_rd;
    logic [3:0]  l1_wmask = 0;
    logic        m1_rd, m1_wr;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic [31:0] word1 = 0;
    logic [3:0]  pipe1;

    // instance with MEM_LAT=3
    logic        i3_v = 0, i3_rdy, i3_rv;
    logic [31:0] i3_addr = 0, i3_rd;
    logic        l3_v = 0, l3_rdy, l3_wen = 0, l3_rv;
    logic [31:0] l3_addr = 0, l3_wdata = 0, l3_rd;
    logic [3:0]  l3_wmask = 0;
    logic        m3_rd, m3_wr;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic [3:0]  m3_wmask;
    logic [31:0] word3 = 0;
    logic [3:0]  pipe3;

    always #5 clk = ~clk;

    ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req_valid(i1_v), .ifu_req_ready(i1_rdy), .ifu_req_addr(i1_addr),
        .ifu_resp_valid(i1_rv), .ifu_resp_data(i1_rd),
        .lsu_req_valid(l1_v), .lsu_req_ready(l1_rdy), .lsu_req_addr(l1_addr),
        .lsu_req_wen(l1_wen), .lsu_req_wdata(l1_wdata), .lsu_req_wmask(l1_wmask),
        .lsu_resp_valid(l1_rv), .lsu_resp_data(l1_rd),
        .mem_rd(m1_rd), .mem_wr(m1_wr), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_wmask(m1_wmask), .mem_rdata(m1_rdata)
    );

    ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req_valid(i3_v), .ifu_req_ready(i3_rdy), .ifu_req_addr(i3_addr),
        .ifu_resp_valid(i3_rv), .ifu_resp_data(i3_rd),
        .lsu_req_valid(l3_v), .lsu_req_ready(l3_rdy), .lsu_req_addr(l3_addr),
        .lsu_req_wen(l3_wen), .lsu_req_wdata(l3_wdata), .lsu_req_wmask(l3_wmask),
        .lsu_resp_valid(l3_rv), .lsu_resp_data(l3_rd),
        .mem_rd(m3_rd), .mem_wr(m3_wr), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_wmask(m3_wmask), .mem_rdata(m3_rdata)
    );

    // Memory model: data is only meaningful in the cycle MEM_LAT after the read strobe.
    always @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            pipe1 <= 4'd0;
            pipe3 <= 4'd0;
        end else begin
            pipe1 <= {pipe1[2:0], m1_rd};
            pipe3 <= {pipe3[2:0], m3_rd};
        end
    end
    assign m1_rdata = pipe1[0] ? word1 : 32'hBAD0BAD0;
    assign m3_rdata = pipe3[2] ? word3 : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, pulses, rd_cnt, resp_at, resp_cnt;
        logic [31:0] cap;
        logic [5:0] grants;
        logic [5:0] exp_grants;
        exp_grants = 6'b101010;

        // reset state
        tick(); tick();
        check("rst_mem_rd", 32'(m1_rd), 32'd0);
        check("rst_mem_wr", 32'(m1_wr), 32'd0);
        check("rst_mem_addr", m1_addr, 32'd0);
        check("rst_mem_wdata", m1_wdata, 32'd0);
        check("rst_mem_wmask", 32'(m1_wmask), 32'd0);
        check("rst_ifu_rv", 32'(i1_rv), 32'd0);
        check("rst_lsu_rv", 32'(l1_rv), 32'd0);
        check("rst_ifu_rd", i1_rd, 32'd0);
        check("rst_lsu_rd", l1_rd, 32'd0);
        check("rst_ifu_rdy", 32'(i1_rdy), 32'd0);
        check("rst_lsu_rdy", 32'(l1_rdy), 32'd0);
        rstn_in = 1'b1;
        tick();

        // IFU fetch, MEM_LAT=1
        word1 = 32'h00100093; i1_addr = 32'h80000000; i1_v = 1; #1;
        check("fetch_ready", 32'(i1_rdy), 32'd1);
        tick(); i1_v = 0;
        check("fetch_mem_rd", 32'(m1_rd), 32'd1);
        check("fetch_mem_wr", 32'(m1_wr), 32'd0);
        check("fetch_mem_addr", m1_addr, 32'h80000000);
        check("fetch_ready_busy", 32'(i1_rdy), 32'd0);
        tick();
        check("fetch_mem_rd_once", 32'(m1_rd), 32'd0);
        check("fetch_rv_early", 32'(i1_rv), 32'd0);
        tick();
        check("fetch_rv", 32'(i1_rv), 32'd1);
        check("fetch_data", i1_rd, 32'h00100093);
        check("fetch_lsu_rv", 32'(l1_rv), 32'd0);
        tick();
        check("fetch_rv_pulse", 32'(i1_rv), 32'd0);

        // LSU store
        word1 = 32'hFFFFFFFF;
        l1_addr = 32'h80001000; l1_wdata = 32'hDEADBEEF; l1_wmask = 4'b1111; l1_wen = 1; l1_v = 1; #1;
        check("store_ready", 32'(l1_rdy), 32'd1);
        tick(); l1_v = 0;
        check("store_mem_wr", 32'(m1_wr), 32'd1);
        check("store_mem_rd", 32'(m1_rd), 32'd0);
        check("store_addr", m1_addr, 32'h80001000);
        check("store_wdata", m1_wdata, 32'hDEADBEEF);
        check("store_wmask", 32'(m1_wmask), 32'hF);
        tick();
        check("store_mem_wr_once", 32'(m1_wr), 32'd0);
        check("store_mem_rd_none", 32'(m1_rd), 32'd0);
        tick();
        check("store_rv", 32'(l1_rv), 32'd1);
        check("store_data_zero", l1_rd, 32'd0);
        check("store_no_rd", 32'(m1_rd), 32'd0);
        tick();
        l1_wen = 0;

        // both valid every IDLE: grants must alternate starting with IFU
        i1_addr = 32'h80000100; l1_addr = 32'h80000200; i1_v = 1; l1_v = 1;
        n = 0; grants = '0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            #1;
            if (i1_rdy && l1_rdy) check("arb_exclusive", 32'd1, 32'd0);
            if (i1_rdy) begin grants[n] = 1'b0; n++; end
            else if (l1_rdy) begin grants[n] = 1'b1; n++; end
            tick();
        end
        i1_v = 0; l1_v = 0;
        check("arb_grant_count", 32'(n), 32'd6);
        check("arb_order", 32'(grants), 32'(exp_grants));
        repeat (5) tick();

        // reset during WAIT of an IFU read
        word1 = 32'h55555555; i1_addr = 32'h80000008; i1_v = 1; #1;
        check("rstw_ready", 32'(i1_rdy), 32'd1);
        tick(); i1_v = 0;
        tick();
        rstn_in = 0; #1;
        check("rstw_mem_rd", 32'(m1_rd), 32'd0);
        check("rstw_mem_wr", 32'(m1_wr), 32'd0);
        check("rstw_mem_addr", m1_addr, 32'd0);
        check("rstw_ifu_rv", 32'(i1_rv), 32'd0);
        check("rstw_ifu_rd", i1_rd, 32'd0);
        tick(); rstn_in = 1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (i1_rv || m1_rd) pulses++;
            tick();
        end
        check("rstw_no_resp", 32'(pulses), 32'd0);
        word1 = 32'h11223344; i1_addr = 32'h80000004; i1_v = 1; #1;
        check("rstw_next_ready", 32'(i1_rdy), 32'd1);
        resp_at = 0; cap = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) i1_v = 0;
            if (i1_rv) begin resp_at = k; cap = i1_rd; end
        end
        check("rstw_next_latency", 32'(resp_at), 32'd3);
        check("rstw_next_data", cap, 32'h11223344);

        // IFU raises then drops valid while LSU is busy
        word1 = 32'hCAFEF00D; l1_addr = 32'h80000300; l1_wen = 0; l1_v = 1; #1;
        check("drop_lsu_ready", 32'(l1_rdy), 32'd1);
        tick(); l1_v = 0; i1_addr = 32'h80000400; i1_v = 1; #1;
        check("drop_ifu_not_ready", 32'(i1_rdy), 32'd0);
        tick(); i1_v = 0;
        rd_cnt = 0; pulses = 0; resp_cnt = 0; cap = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m1_rd) rd_cnt++;
            if (i1_rv) pulses++;
            if (l1_rv) begin resp_cnt++; cap = l1_rd; end
        end
        check("drop_no_ifu_rd", 32'(rd_cnt), 32'd0);
        check("drop_no_ifu_resp", 32'(pulses), 32'd0);
        check("drop_lsu_resp_cnt", 32'(resp_cnt), 32'd1);
        check("drop_lsu_data", cap, 32'hCAFEF00D);

        // MEM_LAT=3 LSU load
        word3 = 32'h12345678; l3_addr = 32'h80002000; l3_wen = 0; l3_v = 1; #1;
        check("lat3_ready", 32'(l3_rdy), 32'd1);
        rd_cnt = 0; resp_at = 0; resp_cnt = 0; cap = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) begin
                l3_v = 0;
                check("lat3_addr", m3_addr, 32'h80002000);
            end
            if (m3_rd) rd_cnt++;
            if (l3_rv) begin resp_at = k; resp_cnt++; cap = l3_rd; end
        end
        check("lat3_latency", 32'(resp_at), 32'd5);
        check("lat3_resp_cnt", 32'(resp_cnt), 32'd1);
        check("lat3_data", cap, 32'h12345678);
        check("lat3_rd_once", 32'(rd_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
